// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared decode types: format codes, RV opcodes, buffered entry layout.
package decode_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // XLEN-wide fields (pc, imm) live in parallel arrays inside the stage.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        fmt_e       fmt;
        logic       illegal;
    } decode_entry_t;

endpackage

// File: rtl/decode_imm_gen.sv
// rtl/decode_imm_gen.sv - combinational format classifier and sign-extended immediate generator.
import decode_pkg::*;

module decode_imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [2:0]      fmt_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    fmt_e        fmt;
    logic [31:0] imm32;

    always_comb begin
        fmt   = FMT_ILL;
        imm32 = '0;
        case (instr_i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM, OPC_MISC_MEM: begin
                fmt   = FMT_I;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPC_OP: fmt = FMT_R;
            // Word-sized ops only exist on RV64.
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    fmt   = FMT_I;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            OPC_OP_32: begin
                if (XLEN == 64) fmt = FMT_R;
            end
            default: ;
        endcase
        if (instr_i[1:0] != 2'b11) begin
            fmt   = FMT_ILL;
            imm32 = '0;
        end
    end

    assign fmt_o     = fmt;
    assign illegal_o = (fmt == FMT_ILL);
    assign imm_o     = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I/RV64I decode stage with DEPTH-entry output FIFO.
// DECODE_STAGE_STATS_EN adds wrapping push / illegal-push counters (cleared by reset only).
import decode_pkg::*;

module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
`ifdef DECODE_STAGE_STATS_EN
    ,
    output logic [31:0]     stat_decoded,
    output logic [31:0]     stat_illegal
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_MAX = DEPTH;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    decode_entry_t    entry_q [DEPTH];
    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  imm_q   [DEPTH];

    decode_entry_t    new_entry;
    logic [2:0]       dec_fmt;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;
    logic             push, pop, accept;

    decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i   (in_instr),
        .fmt_o     (dec_fmt),
        .imm_o     (dec_imm),
        .illegal_o (dec_illegal)
    );

    assign in_ready  = (count_q < CNT_MAX);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // Flush wins over a same-cycle push, so the offered word is never stored.
    assign accept    = push && !flush;

    always_comb begin
        new_entry         = '0;
        new_entry.opcode  = in_instr[6:0];
        new_entry.funct3  = in_instr[14:12];
        new_entry.funct7  = in_instr[31:25];
        new_entry.rs1     = in_instr[19:15];
        new_entry.rs2     = in_instr[24:20];
        new_entry.rd      = in_instr[11:7];
        new_entry.fmt     = fmt_e'(dec_fmt);
        new_entry.illegal = dec_illegal;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            entry_q[wr_ptr_q] <= new_entry;
            pc_q[wr_ptr_q]    <= in_pc;
            imm_q[wr_ptr_q]   <= dec_imm;
        end
    end

    always_comb begin
        out_pc      = '0;
        out_opcode  = '0;
        out_funct3  = '0;
        out_funct7  = '0;
        out_rs1     = '0;
        out_rs2     = '0;
        out_rd      = '0;
        out_imm     = '0;
        out_fmt     = '0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_pc      = pc_q[rd_ptr_q];
            out_opcode  = entry_q[rd_ptr_q].opcode;
            out_funct3  = entry_q[rd_ptr_q].funct3;
            out_funct7  = entry_q[rd_ptr_q].funct7;
            out_rs1     = entry_q[rd_ptr_q].rs1;
            out_rs2     = entry_q[rd_ptr_q].rs2;
            out_rd      = entry_q[rd_ptr_q].rd;
            out_imm     = imm_q[rd_ptr_q];
            out_fmt     = entry_q[rd_ptr_q].fmt;
            out_illegal = entry_q[rd_ptr_q].illegal;
        end
    end

`ifdef DECODE_STAGE_STATS_EN
    logic [31:0] stat_decoded_q, stat_illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_decoded_q <= '0;
            stat_illegal_q <= '0;
        end else if (accept) begin
            stat_decoded_q <= stat_decoded_q + 32'd1;
            if (dec_illegal) stat_illegal_q <= stat_illegal_q + 32'd1;
        end
    end

    assign stat_decoded = stat_decoded_q;
    assign stat_illegal = stat_illegal_q;
`endif

endmodule
